// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Round-robin arbiter between a CPU port and a debug/loader port
//             for a single data memory; 3-cycle IDLE/ACCESS/RESP transaction.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic        dbg_err,
    output logic [31:0] dbg_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [31:0] c_words = 32'(WORDS);

    state_t      r_state;
    state_t      w_next_state;

    logic        r_last_dbg;
    logic        r_gnt_dbg;
    logic        r_we;
    logic        r_in_range;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_we;
    logic        r_mem_re;
    logic        r_cpu_ack;
    logic        r_cpu_err;
    logic [31:0] r_cpu_rdata;
    logic        r_dbg_ack;
    logic        r_dbg_err;
    logic [31:0] r_dbg_rdata;

    logic        w_grant;
    logic        w_pick_dbg;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_sel_in_range;
    logic [31:0] w_rsp_rdata;

    // On a tie the port that did not win last time is picked.
    assign w_grant        = (r_state == S_IDLE) && (cpu_req || dbg_req);
    assign w_pick_dbg     = dbg_req && (!cpu_req || !r_last_dbg);
    assign w_sel_we       = w_pick_dbg ? dbg_we    : cpu_we;
    assign w_sel_addr     = w_pick_dbg ? dbg_addr  : cpu_addr;
    assign w_sel_wdata    = w_pick_dbg ? dbg_wdata : cpu_wdata;
    assign w_sel_in_range = (w_sel_addr < c_words);
    assign w_rsp_rdata    = (r_in_range && !r_we) ? mem_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (cpu_req || dbg_req) w_next_state = S_ACCESS;
            S_ACCESS: w_next_state = S_RESP;
            S_RESP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Strobes are launched on the grant edge so they are visible during ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_dbg  <= 1'b1;
            r_gnt_dbg   <= 1'b0;
            r_we        <= 1'b0;
            r_in_range  <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_cpu_rdata <= 32'h0;
            r_dbg_ack   <= 1'b0;
            r_dbg_err   <= 1'b0;
            r_dbg_rdata <= 32'h0;
        end else begin
            r_mem_we  <= 1'b0;
            r_mem_re  <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_dbg_ack <= 1'b0;
            if (w_grant) begin
                r_last_dbg  <= w_pick_dbg;
                r_gnt_dbg   <= w_pick_dbg;
                r_we        <= w_sel_we;
                r_in_range  <= w_sel_in_range;
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
                r_mem_we    <= w_sel_we && w_sel_in_range;
                r_mem_re    <= !w_sel_we && w_sel_in_range;
            end
            if (r_state == S_ACCESS) begin
                if (r_gnt_dbg) begin
                    r_dbg_ack   <= 1'b1;
                    r_dbg_err   <= !r_in_range;
                    r_dbg_rdata <= w_rsp_rdata;
                end else begin
                    r_cpu_ack   <= 1'b1;
                    r_cpu_err   <= !r_in_range;
                    r_cpu_rdata <= w_rsp_rdata;
                end
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;
    assign cpu_ack   = r_cpu_ack;
    assign cpu_err   = r_cpu_err;
    assign cpu_rdata = r_cpu_rdata;
    assign dbg_ack   = r_dbg_ack;
    assign dbg_err   = r_dbg_err;
    assign dbg_rdata = r_dbg_rdata;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Scoreboard bench for dmem_arbiter with a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int WORDS = 32;
    localparam int AW    = $clog2(WORDS);

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_ack, cpu_err;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_ack, dbg_err;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re, busy;

    always #5 clk = ~clk;

    dmem_arbiter #(.WORDS(WORDS)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [31:0] init_val(input int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // Data memory attached to the arbiter.
    logic [31:0] ram [WORDS];
    bit          ram_fresh = 1'b1;
    assign mem_rdata = (mem_addr < 32'(WORDS)) ? ram[mem_addr[AW-1:0]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
        if (ram_fresh) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= init_val(i);
            ram_fresh <= 1'b0;
        end else if (mem_we && mem_addr < 32'(WORDS)) begin
            ram[mem_addr[AW-1:0]] <= mem_wdata;
        end
    end

    typedef struct { int cyc; bit port; bit err; logic [31:0] rdata; } ack_t;
    typedef struct { int cyc; bit we; logic [31:0] addr; logic [31:0] wdata; } stb_t;

    ack_t        aq[$];
    stb_t        sq[$];
    logic [31:0] ref_mem [WORDS];
    int          edge_no     = 0;
    int          m_busy      = 0;
    bit          m_last_dbg  = 1'b1;
    int          vectors     = 0;
    int          miscompares = 0;

    // Transaction-level reference: one grant per free slot, 3 cycles per transaction.
    always @(posedge clk) begin : model
        bit          g, we, inr;
        logic [31:0] a, d;
        if (edge_no == 0)
            for (int i = 0; i < WORDS; i++) ref_mem[i] = init_val(i);
        if (reset) begin
            aq.delete();
            sq.delete();
            m_busy     = 0;
            m_last_dbg = 1'b1;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (cpu_req || dbg_req) begin
            g   = (cpu_req && dbg_req) ? !m_last_dbg : dbg_req;
            we  = g ? dbg_we    : cpu_we;
            a   = g ? dbg_addr  : cpu_addr;
            d   = g ? dbg_wdata : cpu_wdata;
            inr = (a < 32'(WORDS));
            if (inr) sq.push_back('{edge_no + 1, we, a, d});
            aq.push_back('{edge_no + 2, g, !inr, (inr && !we) ? ref_mem[a[AW-1:0]] : 32'h0});
            if (inr && we) ref_mem[a[AW-1:0]] = d;
            m_busy     = 2;
            m_last_dbg = g;
        end
        edge_no++;
    end

    always @(negedge clk) begin : monitor
        ack_t e;
        stb_t s;
        bit   exp_ack, exp_stb;
        vectors++;
        if (busy !== (m_busy != 0)) begin
            miscompares++;
            $display("FAIL busy @%0d: got %b, want %b", edge_no, busy, m_busy != 0);
        end
        exp_stb = (sq.size() > 0) && (sq[0].cyc == edge_no);
        if (mem_we || mem_re || exp_stb) begin
            vectors++;
            if (!exp_stb) begin
                miscompares++;
                $display("FAIL strobe @%0d: got we=%b re=%b addr=%h, want no strobe",
                         edge_no, mem_we, mem_re, mem_addr);
            end else begin
                s = sq.pop_front();
                if (mem_we !== s.we || mem_re !== !s.we || mem_addr !== s.addr ||
                    (s.we && mem_wdata !== s.wdata)) begin
                    miscompares++;
                    $display("FAIL strobe @%0d: got we=%b re=%b addr=%h wdata=%h, want we=%b re=%b addr=%h wdata=%h",
                             edge_no, mem_we, mem_re, mem_addr, mem_wdata, s.we, !s.we, s.addr, s.wdata);
                end
            end
        end
        exp_ack = (aq.size() > 0) && (aq[0].cyc == edge_no);
        if (cpu_ack || dbg_ack || exp_ack) begin
            vectors++;
            if (!exp_ack) begin
                miscompares++;
                $display("FAIL ack @%0d: got cpu_ack=%b dbg_ack=%b, want none", edge_no, cpu_ack, dbg_ack);
            end else begin
                e = aq.pop_front();
                if (cpu_ack !== !e.port || dbg_ack !== e.port ||
                    (e.port ? dbg_err : cpu_err) !== e.err ||
                    (e.port ? dbg_rdata : cpu_rdata) !== e.rdata) begin
                    miscompares++;
                    $display("FAIL ack @%0d: got cpu_ack=%b dbg_ack=%b err=%b rdata=%h, want port=%0d err=%b rdata=%h",
                             edge_no, cpu_ack, dbg_ack, e.port ? dbg_err : cpu_err,
                             e.port ? dbg_rdata : cpu_rdata, e.port, e.err, e.rdata);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit port, input bit req, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
        if (port) begin
            dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end
    endtask

    // Raise req, wait for this port's ack, then drop req unless chaining another request.
    task automatic do_txn(input bit port, input bit we, input logic [31:0] a,
                          input logic [31:0] d, input bit keep);
        bit got = 1'b0;
        drive(port, 1'b1, we, a, d);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = port ? dbg_ack : cpu_ack;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout port=%0d: got no ack in 40 cycles, want ack=1", port);
        end
        if (!keep) drive(port, 1'b0, we, a, d);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            7:       return 32'(WORDS);
            8:       return 32'hFFFF_FFFF;
            9:       return 32'h8000_0000 | $urandom_range(0, WORDS - 1);
            default: return $urandom_range(0, WORDS - 1);
        endcase
    endfunction

    task automatic agent(input bit port, input int n);
        int gap = $urandom_range(0, 3);
        int nxt;
        for (int k = 0; k < n; k++) begin
            repeat (gap) @(negedge clk);
            nxt = $urandom_range(0, 3);
            do_txn(port, bit'($urandom_range(0, 1)), rand_addr(), $urandom,
                   (k < n - 1) && (nxt == 0));
            gap = nxt;
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'h0);
        check("rst_dbg_ack", 32'(dbg_ack), 32'h0);
        check("rst_cpu_err", 32'(cpu_err), 32'h0);
        check("rst_dbg_err", 32'(dbg_err), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_re", 32'(mem_re), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_dbg_rdata", dbg_rdata, 32'h0);
        reset = 1'b0;

        // First tie after reset: cpu store wins, dbg load then sees the new data.
        fork
            do_txn(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0);
            do_txn(1'b1, 1'b0, 32'd5, 32'h0, 1'b0);
        join
        check("tie_dbg_rdata", dbg_rdata, 32'hDEAD_BEEF);
        check("store_cpu_rdata", cpu_rdata, 32'h0);
        do_txn(1'b0, 1'b0, 32'd5, 32'h0, 1'b0);
        check("load_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);

        do_txn(1'b1, 1'b0, 32'(WORDS), 32'h0, 1'b0);
        check("oor_dbg_err", 32'(dbg_err), 32'h1);
        check("oor_dbg_rdata", dbg_rdata, 32'h0);

        fork
            for (int k = 0; k < 4; k++) do_txn(1'b0, k[0], 32'(k + 10), $urandom, k < 3);
            for (int k = 0; k < 4; k++) do_txn(1'b1, !k[0], 32'(k + 20), $urandom, k < 3);
        join

        // Reset during ACCESS of a cpu store.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'd9, 32'h1234_5678);
        @(negedge clk);
        check("mid_mem_we", 32'(mem_we), 32'h1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_cpu_ack", 32'(cpu_ack), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_cpu_ack_after", 32'(cpu_ack), 32'h0);
        do_txn(1'b0, 1'b0, 32'd9, 32'h0, 1'b0);
        check("mid_reload", cpu_rdata, 32'h1234_5678);

        // dbg request rises while the cpu transaction is in RESP.
        do_txn(1'b0, 1'b1, 32'd3, 32'hCAFE_F00D, 1'b0);
        do_txn(1'b1, 1'b0, 32'd3, 32'h0, 1'b0);
        check("late_dbg_rdata", dbg_rdata, 32'hCAFE_F00D);

        fork
            agent(1'b0, 60);
            agent(1'b1, 60);
        join
        repeat (5) @(negedge clk);
        check("drain", 32'(aq.size() + sq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter WORDS, default 32: number of data-memory words; valid word addresses are 0..WORDS-1.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 Ports cpu_req / cpu_we, inputs, 1 each: CPU load/store request; we=1 is store, we=0 is load.
REQ-005 Ports cpu_addr / cpu_wdata, inputs, 32 each: CPU word address and store data.
REQ-006 Ports cpu_ack / cpu_err, outputs, 1 each: one-cycle completion pulse; err flags an out-of-range address.
REQ-007 Port cpu_rdata, output, 32: CPU load data, valid while cpu_ack=1.
REQ-008 Ports dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_err, dbg_rdata: debug/loader port, identical widths and meaning to the cpu_* ports.
REQ-009 Ports mem_addr / mem_wdata, outputs, 32 each: address and write data driven to the data memory.
REQ-010 Ports mem_we / mem_re, outputs, 1 each: data-memory write and read strobes.
REQ-011 Port mem_rdata, input, 32: combinational read data returned by the data memory.
REQ-012 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-014 Sequence: IDLE with any req=1 at edge E goes to ACCESS; ACCESS always goes to RESP; RESP always goes to IDLE. A transaction occupies exactly 3 cycles.
REQ-015 Arbitration in IDLE: a lone requester is granted. When both request, the port not granted last SHALL win (round-robin). The last-grant pointer resets to dbg, so cpu wins the first tie.
REQ-016 At the grant edge, the granted port's we, addr and wdata SHALL be latched internally. Requester inputs are don't-care after that edge.
REQ-017 mem_addr, mem_wdata, mem_we and mem_re SHALL be registered outputs.
REQ-018 In ACCESS, exactly one strobe SHALL be high for exactly one cycle: mem_we for a store, mem_re for a load. Both strobes are 0 in every other state.
REQ-019 Address-range rule: if latched addr >= WORDS, no strobe SHALL assert in ACCESS, and RESP SHALL report err=1 with rdata=0.
REQ-020 Load completion: at the ACCESS→RESP edge, mem_rdata SHALL be captured into the granted port's rdata.
REQ-021 Store completion: the granted port's rdata SHALL be 0.
REQ-022 In RESP, the granted port's ack SHALL be 1 for exactly one cycle. The other port's ack and err SHALL stay 0.
REQ-023 Latency: a request sampled at edge N SHALL produce a strobe in cycle N+1 and ack in cycle N+2. Earliest next grant is at the end of cycle N+3.
REQ-024 Requester contract: a requester SHALL hold req and operands stable until ack and clear req on the edge where ack=1. A req still high in IDLE is a new transaction.
REQ-025 A request arriving while busy=1 SHALL be held pending and considered at the next IDLE. There SHALL be no queuing beyond the level of req.
REQ-026 rdata and err SHALL hold their last value between acks. ack is the only qualifier.
REQ-027 Address compare SHALL use the full 32 bits. There is no wrap or truncation, and mem_addr carries the latched address unmodified.

Reset
REQ-028 reset=1 at an edge SHALL force: state IDLE; last-grant = dbg; all ack, err and strobes = 0; mem_addr, mem_wdata and both rdata = 0; busy = 0.
REQ-029 Reset in ACCESS or RESP SHALL abandon the transaction with no ack and no further strobe. A strobe already issued in ACCESS is not undone.
REQ-030 reset SHALL take priority over any simultaneous request.

Verification
REQ-031 Store sequence: cpu store addr=5, wdata=0xDEADBEEF → mem_we=1, mem_addr=5, mem_wdata=0xDEADBEEF in cycle N+1 → cpu_ack=1, err=0 in N+2. Then cpu load addr=5 → cpu_rdata=0xDEADBEEF with ack.
REQ-032 First tie: cpu and dbg both request at the first edge after reset → cpu granted first, dbg granted at the next IDLE (ack 3 cycles later).
REQ-033 Repeated ties: continuous requests from both ports → grants alternate cpu, dbg, cpu, dbg. Each port receives one ack every 6 cycles.
REQ-034 Out-of-range: dbg load addr=32 (WORDS=32) → no strobe; dbg_ack=1, dbg_err=1, dbg_rdata=0 in N+2.
REQ-035 Reset mid-transaction: reset asserted in ACCESS of a cpu store → next cycle IDLE, busy=0, no cpu_ack. A following request completes normally.
REQ-036 Late request while busy: dbg_req rises while a cpu transaction is in RESP → dbg is granted at the first IDLE edge, and mem_re asserts 2 cycles after RESP.
